// File: rtl/pit_tick.sv
// pit_tick: programmable interval timer.
// A W-bit prescaler cascades into a W-bit divider. Expiry produces a
// registered one-cycle tick and sets a sticky irq flag. The period is
// (PRE+1)*(DIV+1) clocks. Any register write reloads both counters and
// discards an expiry that falls on the same edge.
module pit_tick #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         wr_pre,
    input  logic         wr_div,
    input  logic         halt,
    input  logic         irq_ack,
    output logic         tick,
    output logic         irq,
    output logic [W-1:0] pre_cnt,
    output logic [W-1:0] div_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } mode_t;

    mode_t        mode;
    logic [W-1:0] pre_q, pre_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] pcnt_q, pcnt_d;
    logic [W-1:0] dcnt_q, dcnt_d;
    logic         tick_q, tick_d;
    logic         irq_q, irq_d;
    logic         expiry;

    // Operating mode follows PRE and halt directly, with no pipeline delay.
    always_comb begin
        mode = IDLE;
        if (pre_q != '0) begin
            mode = halt ? HOLD : RUN;
        end
    end

    // Next-state logic for the registers, counters, tick and irq.
    always_comb begin
        pre_d  = pre_q;
        div_d  = div_q;
        pcnt_d = pcnt_q;
        dcnt_d = dcnt_q;
        expiry = 1'b0;

        if (wr_pre || wr_div) begin
            // Writes win over counting in every mode.
            if (wr_pre) pre_d = din;
            if (wr_div) div_d = din;
            // A timer left disabled by the write reads zero on both counters.
            if (pre_d != '0) begin
                pcnt_d = pre_d;
                dcnt_d = div_d;
            end else begin
                pcnt_d = '0;
                dcnt_d = '0;
            end
        end else begin
            case (mode)
                RUN: begin
                    if (pcnt_q != '0) begin
                        pcnt_d = pcnt_q - 1'b1;
                    end else begin
                        pcnt_d = pre_q;
                        if (dcnt_q != '0) begin
                            dcnt_d = dcnt_q - 1'b1;
                        end else begin
                            dcnt_d = div_q;
                            expiry = 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and HOLD keep the counters frozen.
                end
            endcase
        end

        tick_d = expiry;
        // A new expiry takes priority over an acknowledge in the same cycle.
        if (expiry) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            div_q  <= '0;
            pcnt_q <= '0;
            dcnt_q <= '0;
            tick_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            div_q  <= div_d;
            pcnt_q <= pcnt_d;
            dcnt_q <= dcnt_d;
            tick_q <= tick_d;
            irq_q  <= irq_d;
        end
    end

    assign tick    = tick_q;
    assign irq     = irq_q;
    assign pre_cnt = pcnt_q;
    assign div_cnt = dcnt_q;

endmodule

// File: tb/tb_pit_tick.sv
// Bench for pit_tick: a directed table, hand-written corner sequences and
// randomized traffic, all checked against a position-in-period model.
module tb_pit_tick;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         wr_pre = 1'b0;
    logic         wr_div = 1'b0;
    logic         halt = 1'b0;
    logic         irq_ack = 1'b0;
    logic         tick;
    logic         irq;
    logic [W-1:0] pre_cnt;
    logic [W-1:0] div_cnt;

    pit_tick #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .wr_pre  (wr_pre),
        .wr_div  (wr_div),
        .halt    (halt),
        .irq_ack (irq_ack),
        .tick    (tick),
        .irq     (irq),
        .pre_cnt (pre_cnt),
        .div_cnt (div_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: programmed values plus the number of counting edges taken
    // inside the current period.
    longint m_pre = 0;
    longint m_div = 0;
    longint m_pos = 0;
    logic   m_tick = 1'b0;
    logic   m_irq = 1'b0;

    function automatic logic [W-1:0] exp_pre();
        if (m_pre == 0) return '0;
        return W'(m_pre - (m_pos % (m_pre + 1)));
    endfunction

    function automatic logic [W-1:0] exp_div();
        if (m_pre == 0) return '0;
        return W'(m_div - (m_pos / (m_pre + 1)));
    endfunction

    task automatic model_reset();
        m_pre = 0; m_div = 0; m_pos = 0; m_tick = 1'b0; m_irq = 1'b0;
    endtask

    task automatic model_step(input logic wp, input logic wd, input logic [W-1:0] d,
                              input logic h, input logic a);
        logic ex;
        ex = 1'b0;
        if (wp || wd) begin
            if (wp) m_pre = longint'(d);
            if (wd) m_div = longint'(d);
            m_pos = 0;
        end else if (m_pre != 0 && !h) begin
            m_pos++;
            if (m_pos == (m_pre + 1) * (m_div + 1)) begin
                m_pos = 0;
                ex = 1'b1;
            end
        end
        m_tick = ex;
        if (ex) m_irq = 1'b1;
        else if (a) m_irq = 1'b0;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // One clock of stimulus; outputs are compared with the model 1ns after the edge.
    task automatic step(input logic wp, input logic wd, input logic [W-1:0] d,
                        input logic h, input logic a, input string nm);
        @(negedge clk);
        wr_pre = wp; wr_div = wd; din = d; halt = h; irq_ack = a;
        @(posedge clk);
        model_step(wp, wd, d, h, a);
        #1;
        check(nm, {30'd0, tick, irq, pre_cnt, div_cnt},
              {30'd0, m_tick, m_irq, exp_pre(), exp_div()});
    endtask

    typedef struct {
        logic         wp;
        logic         wd;
        logic [W-1:0] d;
        logic         h;
        logic         a;
        logic         t;
        logic         q;
        logic [W-1:0] pc;
        logic [W-1:0] dc;
    } vec_t;

    vec_t tbl [17];
    int   n;
    int   cnt;
    logic found;

    initial begin
        // PRE=2 then DIV=1: period 6, irq set/ack interplay.
        tbl[0]  = '{1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
        tbl[2]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[3]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1};
        tbl[4]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[7]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd1};
        tbl[8]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[9]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1};
        tbl[10] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0};
        tbl[11] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
        tbl[12] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        tbl[13] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2, 16'd1};
        tbl[14] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 16'd1};
        tbl[15] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd1};
        tbl[16] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd0};

        // Power-on reset.
        #12;
        check("reset_state", {30'd0, tick, irq, pre_cnt, div_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].wp, tbl[i].wd, tbl[i].d, tbl[i].h, tbl[i].a, "tbl_model");
            check($sformatf("tbl_%0d", i), {30'd0, tick, irq, pre_cnt, div_cnt},
                  {30'd0, tbl[i].t, tbl[i].q, tbl[i].pc, tbl[i].dc});
        end

        // PRE=1, DIV=0: tick every other cycle.
        step(1'b1, 1'b0, 16'd1, 1'b0, 1'b1, "alt_wr_pre");
        step(1'b0, 1'b1, 16'd0, 1'b0, 1'b0, "alt_wr_div");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "alt_run");
            if (tick) cnt++;
        end
        check("alt_tick_count", 64'(cnt), 64'd5);

        // Writing PRE=0 mid-run stops the timer; counters read zero.
        step(1'b0, 1'b1, 16'd3, 1'b0, 1'b0, "stop_wr_div");
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "stop_run");
        step(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, "stop_wr_pre0");
        check("stop_counters", {32'd0, pre_cnt, div_cnt}, 64'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "stop_idle");
            if (tick) cnt++;
        end
        check("stop_no_tick", 64'(cnt), 64'd0);

        // Write DIV=7 on the exact expiry edge with PRE=2, DIV=0.
        step(1'b1, 1'b0, 16'd2, 1'b0, 1'b0, "expwr_pre");
        step(1'b0, 1'b1, 16'd0, 1'b0, 1'b0, "expwr_div0");
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "expwr_run");
        step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "expwr_run");
        step(1'b0, 1'b1, 16'd7, 1'b0, 1'b0, "expwr_div7");
        check("expwr_discard", {30'd0, tick, 1'b0, pre_cnt, div_cnt},
              {30'd0, 1'b0, 1'b0, 16'd2, 16'd7});
        n = 0; found = 1'b0;
        while (!found && n < 40) begin
            step(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, "expwr_wait");
            n++;
            if (tick) found = 1'b1;
        end
        check("expwr_interval", 64'(n), 64'd24);

        // Halt for 4 cycles mid-period with PRE=3, DIV=2: interval 12+4.
        step(1'b1, 1'b0, 16'd3, 1'b0, 1'b0, "halt_wr_pre");
        step(1'b0, 1'b1, 16'd2, 1'b0, 1'b0, "halt_wr_div");
        n = 0; found = 1'b0;
        while (!found && n < 40) begin
            n++;
            step(1'b0, 1'b0, 16'd0, (n >= 6 && n <= 9), 1'b0, "halt_wait");
            if (tick) found = 1'b1;
        end
        check("halt_interval", 64'(n), 64'd16);

        // Asynchronous reset mid-run with PRE=5, DIV=3.
        step(1'b1, 1'b0, 16'd5, 1'b0, 1'b0, "rst_wr_pre");
        step(1'b0, 1'b1, 16'd3, 1'b0, 1'b0, "rst_wr_div");
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "rst_run");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async", {30'd0, tick, irq, pre_cnt, div_cnt}, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, "rst_after");
            if (tick) cnt++;
        end
        check("rst_no_tick", 64'(cnt), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic wp, wd, h, a;
            logic [W-1:0] d;
            wp = ($urandom_range(0, 99) < 3);
            wd = ($urandom_range(0, 99) < 3);
            d  = W'($urandom_range(0, 5));
            h  = ($urandom_range(0, 99) < 15);
            a  = ($urandom_range(0, 99) < 20);
            step(wp, wd, d, h, a, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
